// File: rtl/gpio_defaults_sequencer_if.sv
// rtl/gpio_defaults_sequencer_if.sv - defaults bus and serial chain signals of the sequencer
interface gpio_defaults_sequencer_if #(
  parameter int NUM_GPIO  = 2,
  parameter int CFG_WIDTH = 13
);
  logic                          start;
  logic [NUM_GPIO*CFG_WIDTH-1:0] gpio_defaults;
  logic                          serial_clock;
  logic                          serial_data;
  logic                          serial_load;
  logic                          busy;
  logic                          done;

  modport master (
    input  start,
    output gpio_defaults, serial_clock, serial_data, serial_load, busy, done
  );

  modport slave (
    output start,
    input  gpio_defaults, serial_clock, serial_data, serial_load, busy, done
  );
endinterface

// File: rtl/gpio_defaults_sequencer.sv
// rtl/gpio_defaults_sequencer.sv - drives pad defaults in parallel and shifts them into the control chain
module gpio_defaults_sequencer #(
  parameter int                            NUM_GPIO         = 2,
  parameter int                            CFG_WIDTH        = 13,
  parameter logic [NUM_GPIO*CFG_WIDTH-1:0] GPIO_CONFIG_INIT = {NUM_GPIO{13'h0402}},
  parameter int                            CLK_DIV          = 1,
  parameter bit                            AUTO_LOAD        = 1'b1
) (
  input  logic                       clock,
  input  logic                       resetn,
  gpio_defaults_sequencer_if.master  bus
);
  localparam int TOTAL = NUM_GPIO * CFG_WIDTH;
  localparam int BW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int PW    = $clog2(CLK_DIV + 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(TOTAL - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LOAD} state_t;

  state_t          state;
  logic [BW-1:0]   bit_cnt;
  logic [PW-1:0]   phase_cnt;
  logic            pending;
  logic            sclk_q;
  logic            sdata_q;
  logic            sload_q;
  logic            busy_q;
  logic            done_q;
  logic [TOTAL-1:0] stream;
  logic            phase_end;

  // Stream order is MSB of the highest channel first, bit 0 of channel 0 last.
  always_comb begin
    stream = '0;
    for (int k = 0; k < TOTAL; k++) begin
      stream[k] = GPIO_CONFIG_INIT[TOTAL-1-k];
    end
  end

  assign phase_end = (phase_cnt == PHASE_LAST);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      phase_cnt <= '0;
      pending   <= AUTO_LOAD;
      sclk_q    <= 1'b0;
      sdata_q   <= 1'b0;
      sload_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pending || bus.start) begin
            state     <= SHIFT_LO;
            pending   <= 1'b0;
            bit_cnt   <= '0;
            phase_cnt <= '0;
            busy_q    <= 1'b1;
            sclk_q    <= 1'b0;
            sdata_q   <= stream[0];
          end
        end
        SHIFT_LO: begin
          if (phase_end) begin
            phase_cnt <= '0;
            sclk_q    <= 1'b1;
            state     <= SHIFT_HI;
          end else begin
            phase_cnt <= phase_cnt + PW'(1);
          end
        end
        SHIFT_HI: begin
          if (phase_end) begin
            phase_cnt <= '0;
            sclk_q    <= 1'b0;
            if (bit_cnt != BIT_LAST) begin
              bit_cnt <= bit_cnt + BW'(1);
              sdata_q <= stream[bit_cnt + BW'(1)];
              state   <= SHIFT_LO;
            end else begin
              sdata_q <= 1'b0;
              sload_q <= 1'b1;
              state   <= LOAD;
            end
          end else begin
            phase_cnt <= phase_cnt + PW'(1);
          end
        end
        LOAD: begin
          if (phase_end) begin
            phase_cnt <= '0;
            sload_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state     <= IDLE;
          end else begin
            phase_cnt <= phase_cnt + PW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gpio_defaults = GPIO_CONFIG_INIT;
  assign bus.serial_clock  = sclk_q;
  assign bus.serial_data   = sdata_q;
  assign bus.serial_load   = sload_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
endmodule

// File: tb/tb_gpio_defaults_sequencer.sv
// tb/tb_gpio_defaults_sequencer.sv - directed self-checking bench for gpio_defaults_sequencer
module tb_gpio_defaults_sequencer;
  localparam logic [25:0] INIT_A = {13'h1803, 13'h0402};
  localparam logic [25:0] INIT_C = {13'h0A5C, 13'h1F31};

  logic clock = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  logic rst_c = 1'b0;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clock = ~clock;

  gpio_defaults_sequencer_if #(.NUM_GPIO(2), .CFG_WIDTH(13)) if_a ();
  gpio_defaults_sequencer_if #(.NUM_GPIO(2), .CFG_WIDTH(13)) if_b ();
  gpio_defaults_sequencer_if #(.NUM_GPIO(2), .CFG_WIDTH(13)) if_c ();

  gpio_defaults_sequencer #(.NUM_GPIO(2), .CFG_WIDTH(13), .GPIO_CONFIG_INIT(INIT_A),
                            .CLK_DIV(1), .AUTO_LOAD(1'b1))
    dut_a (.clock(clock), .resetn(rst_a), .bus(if_a.master));
  gpio_defaults_sequencer #(.NUM_GPIO(2), .CFG_WIDTH(13), .GPIO_CONFIG_INIT(INIT_A),
                            .CLK_DIV(1), .AUTO_LOAD(1'b0))
    dut_b (.clock(clock), .resetn(rst_b), .bus(if_b.master));
  gpio_defaults_sequencer #(.NUM_GPIO(2), .CFG_WIDTH(13), .GPIO_CONFIG_INIT(INIT_C),
                            .CLK_DIV(3), .AUTO_LOAD(1'b1))
    dut_c (.clock(clock), .resetn(rst_c), .bus(if_c.master));

  logic [2:0] sclk_v, sdata_v, sload_v, busy_v, done_v;
  assign sclk_v  = {if_c.serial_clock, if_b.serial_clock, if_a.serial_clock};
  assign sdata_v = {if_c.serial_data,  if_b.serial_data,  if_a.serial_data};
  assign sload_v = {if_c.serial_load,  if_b.serial_load,  if_a.serial_load};
  assign busy_v  = {if_c.busy,         if_b.busy,         if_a.busy};
  assign done_v  = {if_c.done,         if_b.done,         if_a.done};

  // Chain model and activity counters, sampled on the falling clock edge.
  logic [25:0] shreg [3] = '{26'd0, 26'd0, 26'd0};
  logic [25:0] cap   [3] = '{26'd0, 26'd0, 26'd0};
  logic        prev_sclk [3] = '{1'b0, 1'b0, 1'b0};
  logic        prev_data [3] = '{1'b0, 1'b0, 1'b0};
  logic        prev_load [3] = '{1'b0, 1'b0, 1'b0};
  int rise_cnt [3] = '{0, 0, 0};
  int load_cyc [3] = '{0, 0, 0};
  int busy_cyc [3] = '{0, 0, 0};
  int done_cnt [3] = '{0, 0, 0};
  int since_chg [3] = '{1000, 1000, 1000};
  int since_rise [3] = '{1000, 1000, 1000};
  int min_setup [3] = '{1000, 1000, 1000};
  int min_hold  [3] = '{1000, 1000, 1000};

  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      prev_sclk[i] <= sclk_v[i];
      prev_data[i] <= sdata_v[i];
      prev_load[i] <= sload_v[i];
      since_chg[i]  <= (sdata_v[i] !== prev_data[i]) ? 0 : since_chg[i] + 1;
      since_rise[i] <= (sclk_v[i] && !prev_sclk[i]) ? 0 : since_rise[i] + 1;
      if ((sdata_v[i] !== prev_data[i]) && (since_rise[i] + 1 < min_hold[i]))
        min_hold[i] <= since_rise[i] + 1;
      if (sclk_v[i] && !prev_sclk[i]) begin
        rise_cnt[i] <= rise_cnt[i] + 1;
        shreg[i]    <= {shreg[i][24:0], sdata_v[i]};
        if (since_chg[i] + 1 < min_setup[i]) min_setup[i] <= since_chg[i] + 1;
      end
      if (sload_v[i]) load_cyc[i] <= load_cyc[i] + 1;
      if (sload_v[i] && !prev_load[i]) cap[i] <= shreg[i];
      if (busy_v[i]) busy_cyc[i] <= busy_cyc[i] + 1;
      if (done_v[i]) done_cnt[i] <= done_cnt[i] + 1;
    end
  end

  task automatic wait_done(input int idx, input int budget, output bit seen);
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clock);
      if (done_v[idx]) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    compared++;
    if ({sclk_v, sdata_v, sload_v, busy_v, done_v} !== 15'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %b required 0", {sclk_v, sdata_v, sload_v, busy_v, done_v});
    end
    compared++;
    if (if_a.gpio_defaults !== INIT_A || if_c.gpio_defaults !== INIT_C) begin
      mismatched++;
      $display("FAIL reset_defaults: got %h/%h required %h/%h",
               if_a.gpio_defaults, if_c.gpio_defaults, INIT_A, INIT_C);
    end
  endtask

  task automatic test_auto_load();
    int r0, l0, b0, d0;
    bit seen;
    r0 = rise_cnt[0]; l0 = load_cyc[0]; b0 = busy_cyc[0]; d0 = done_cnt[0];
    rst_a = 1'b1;
    @(posedge clock); #1;
    compared++;
    if (if_a.busy !== 1'b1 || if_a.serial_data !== 1'b1) begin
      mismatched++;
      $display("FAIL auto_first_edge: busy=%b data=%b required 1/1", if_a.busy, if_a.serial_data);
    end
    wait_done(0, 200, seen);
    repeat (5) @(negedge clock);
    #1;
    compared++;
    if (!seen) begin
      mismatched++;
      $display("FAIL auto_done_timeout: no done within 200 cycles");
    end
    compared++;
    if (rise_cnt[0] - r0 != 26 || load_cyc[0] - l0 != 1 || busy_cyc[0] - b0 != 53 || done_cnt[0] - d0 != 1) begin
      mismatched++;
      $display("FAIL auto_counts: rises=%0d load=%0d busy=%0d done=%0d required 26/1/53/1",
               rise_cnt[0] - r0, load_cyc[0] - l0, busy_cyc[0] - b0, done_cnt[0] - d0);
    end
    compared++;
    if (cap[0] !== INIT_A) begin
      mismatched++;
      $display("FAIL auto_chain_word: got %h required %h", cap[0], INIT_A);
    end
  endtask

  task automatic test_start_gate();
    int r0, b0, activity;
    bit seen;
    activity = 0;
    rst_b = 1'b1;
    r0 = rise_cnt[1]; b0 = busy_cyc[1];
    for (int n = 0; n < 100; n++) begin
      @(negedge clock);
      if ({sclk_v[1], sdata_v[1], sload_v[1], busy_v[1], done_v[1]} !== 5'd0) activity++;
    end
    compared++;
    if (activity != 0 || rise_cnt[1] != r0 || busy_cyc[1] != b0) begin
      mismatched++;
      $display("FAIL noauto_idle: active cycles=%0d required 0", activity);
    end
    r0 = rise_cnt[1]; b0 = busy_cyc[1];
    if_b.start = 1'b1;
    @(negedge clock);
    if_b.start = 1'b0;
    wait_done(1, 200, seen);
    repeat (5) @(negedge clock);
    #1;
    compared++;
    if (!seen || rise_cnt[1] - r0 != 26 || busy_cyc[1] - b0 != 53 || cap[1] !== INIT_A) begin
      mismatched++;
      $display("FAIL start_sequence: seen=%0d rises=%0d busy=%0d word=%h required 1/26/53/%h",
               seen, rise_cnt[1] - r0, busy_cyc[1] - b0, cap[1], INIT_A);
    end
  endtask

  task automatic test_back_to_back();
    int r0, l0, b0, d0;
    bit seen, hit;
    r0 = rise_cnt[0]; l0 = load_cyc[0]; b0 = busy_cyc[0]; d0 = done_cnt[0];
    if_a.start = 1'b1;
    @(negedge clock);
    if_a.start = 1'b0;
    hit = 1'b0;
    for (int n = 0; n < 100 && !hit; n++) begin
      @(negedge clock); #1;
      if (rise_cnt[0] - r0 >= 5) hit = 1'b1;
    end
    if_a.start = 1'b1;
    @(negedge clock);
    if_a.start = 1'b0;
    wait_done(0, 200, seen);
    repeat (8) @(negedge clock);
    #1;
    compared++;
    if (!hit || !seen || rise_cnt[0] - r0 != 26 || done_cnt[0] - d0 != 1 || busy_v[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL busy_start_ignored: rises=%0d done=%0d busy=%b required 26/1/0",
               rise_cnt[0] - r0, done_cnt[0] - d0, busy_v[0]);
    end
    if_a.start = 1'b1;
    @(negedge clock);
    if_a.start = 1'b0;
    wait_done(0, 200, seen);
    compared++;
    if (!seen || busy_v[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL done_cycle_busy: seen=%0d busy=%b required 1/0", seen, busy_v[0]);
    end
    if_a.start = 1'b1;
    @(negedge clock);
    if_a.start = 1'b0;
    compared++;
    if (busy_v[0] !== 1'b1) begin
      mismatched++;
      $display("FAIL start_on_done_gap: busy=%b required 1", busy_v[0]);
    end
    wait_done(0, 200, seen);
    repeat (5) @(negedge clock);
    #1;
    compared++;
    if (!seen || rise_cnt[0] - r0 != 78 || load_cyc[0] - l0 != 3 || busy_cyc[0] - b0 != 159 ||
        done_cnt[0] - d0 != 3) begin
      mismatched++;
      $display("FAIL back_to_back_counts: rises=%0d load=%0d busy=%0d done=%0d required 78/3/159/3",
               rise_cnt[0] - r0, load_cyc[0] - l0, busy_cyc[0] - b0, done_cnt[0] - d0);
    end
  endtask

  task automatic test_reset_mid();
    int r0, l0;
    bit seen, hit;
    r0 = rise_cnt[0]; l0 = load_cyc[0];
    if_a.start = 1'b1;
    @(negedge clock);
    if_a.start = 1'b0;
    hit = 1'b0;
    for (int n = 0; n < 100 && !hit; n++) begin
      @(negedge clock); #1;
      if (rise_cnt[0] - r0 >= 10) hit = 1'b1;
    end
    #1;
    rst_a = 1'b0;
    #1;
    compared++;
    if (!hit || {if_a.serial_clock, if_a.serial_data, if_a.serial_load, if_a.busy} !== 4'd0) begin
      mismatched++;
      $display("FAIL async_reset_drop: hit=%0d outs=%b required 1/0000", hit,
               {if_a.serial_clock, if_a.serial_data, if_a.serial_load, if_a.busy});
    end
    repeat (4) @(negedge clock);
    #1;
    compared++;
    if (load_cyc[0] != l0 || if_a.gpio_defaults !== INIT_A) begin
      mismatched++;
      $display("FAIL reset_no_load: load cycles=%0d defaults=%h required 0/%h",
               load_cyc[0] - l0, if_a.gpio_defaults, INIT_A);
    end
    r0 = rise_cnt[0];
    rst_a = 1'b1;
    wait_done(0, 200, seen);
    repeat (3) @(negedge clock);
    #1;
    compared++;
    if (!seen || rise_cnt[0] - r0 != 26 || load_cyc[0] - l0 != 1 || cap[0] !== INIT_A) begin
      mismatched++;
      $display("FAIL restart_after_reset: rises=%0d load=%0d word=%h required 26/1/%h",
               rise_cnt[0] - r0, load_cyc[0] - l0, cap[0], INIT_A);
    end
  endtask

  task automatic test_clk_div3();
    bit seen;
    compared++;
    if (if_c.gpio_defaults !== INIT_C || if_c.busy !== 1'b0) begin
      mismatched++;
      $display("FAIL div3_in_reset: defaults=%h busy=%b required %h/0", if_c.gpio_defaults, if_c.busy, INIT_C);
    end
    rst_c = 1'b1;
    wait_done(2, 400, seen);
    repeat (5) @(negedge clock);
    #1;
    compared++;
    if (!seen || rise_cnt[2] != 26 || load_cyc[2] != 3 || busy_cyc[2] != 159 || done_cnt[2] != 1) begin
      mismatched++;
      $display("FAIL div3_counts: rises=%0d load=%0d busy=%0d done=%0d required 26/3/159/1",
               rise_cnt[2], load_cyc[2], busy_cyc[2], done_cnt[2]);
    end
    compared++;
    if (min_setup[2] != 3 || min_hold[2] != 3) begin
      mismatched++;
      $display("FAIL div3_setup_hold: setup=%0d hold=%0d required 3/3", min_setup[2], min_hold[2]);
    end
    compared++;
    if (cap[2] !== INIT_C || cap[2] !== if_c.gpio_defaults) begin
      mismatched++;
      $display("FAIL div3_chain_word: got %h required %h", cap[2], INIT_C);
    end
  endtask

  initial begin
    if_a.start = 1'b0;
    if_b.start = 1'b0;
    if_c.start = 1'b0;
    test_reset();
    test_auto_load();
    test_start_gate();
    test_back_to_back();
    test_reset_mid();
    test_clk_div3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
